// File: rtl/cdc_rsp_pkg.sv
// Shared constants and FSM state encoding for the cdc_reg_responder byte-command block.
package cdc_rsp_pkg;

    localparam logic [7:0] CMD_RD  = 8'h52;
    localparam logic [7:0] CMD_WR  = 8'h57;
    localparam logic [7:0] RSP_ACK = 8'h06;
    localparam logic [7:0] RSP_NAK = 8'h15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } cdc_rsp_state_e;

endpackage

// File: rtl/cdc_reg_responder.sv
// cdc_reg_responder: decodes 'R' addr / 'W' addr data commands from the usb_cdc OUT
// byte stream and returns exactly one reply byte per command on the IN stream.
// Optional inter-byte timeout is compiled in with the CDC_RSP_TIMEOUT_EN macro.
//
// Handshake rule (both streams): a byte moves on a posedge where valid and ready are
// both high; in_data_o is held stable while in_valid_o is high and in_ready_i is low.
module cdc_reg_responder
    import cdc_rsp_pkg::*;
#(
    parameter int unsigned NREGS       = 16,
    parameter logic [7:0]  ID_VALUE    = 8'hC5,
    parameter int unsigned TIMEOUT_CYC = 12000
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic [7:0]         out_data_i,
    input  logic               out_valid_i,
    output logic               out_ready_o,
    output logic [7:0]         in_data_o,
    output logic               in_valid_o,
    input  logic               in_ready_i,
    output logic [NREGS*8-1:0] regs_o,
    output logic [1:0]         dbg_state_o
);

    cdc_rsp_state_e            state_q, state_d;
    logic                      cmd_wr_q, cmd_wr_d;
    logic [7:0]                addr_q, addr_d;
    logic [7:0]                rsp_q, rsp_d;
    logic [NREGS-1:1][7:0]     regs_q, regs_d;
    logic                      out_ready_q;
    logic                      byte_acc;
    logic [7:0]                rd_val;
    logic [NREGS-1:1]          wr_sel;
    logic                      wr_ok;
    logic                      tmo_hit;

    assign byte_acc = out_valid_i & out_ready_q;

    // Read mux for the address byte currently on the bus; full 8-bit compare, no aliasing.
    always_comb begin
        rd_val = RSP_NAK;
        if (out_data_i == 8'h00) begin
            rd_val = ID_VALUE;
        end
        for (int k = 1; k < int'(NREGS); k++) begin
            if (out_data_i == k[7:0]) begin
                rd_val = regs_q[k];
            end
        end
    end

    // Write decode for the latched address; register 0 and out-of-range never match.
    always_comb begin
        wr_sel = '0;
        for (int k = 1; k < int'(NREGS); k++) begin
            if (addr_q == k[7:0]) begin
                wr_sel[k] = 1'b1;
            end
        end
    end
    assign wr_ok = |wr_sel;

`ifdef CDC_RSP_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_q, tmo_d;

    // Idle-cycle counter while a command is partially received; any accepted byte clears it.
    always_comb begin
        tmo_d   = '0;
        tmo_hit = 1'b0;
        if ((state_q == ST_ADDR || state_q == ST_DATA) && !byte_acc) begin
            if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                tmo_hit = 1'b1;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end
    end

    // Timeout counter register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    logic unused_tmo;
    assign tmo_hit    = 1'b0;
    assign unused_tmo = (TIMEOUT_CYC == 0);
`endif

    // Command FSM next-state, reply byte and register-file update.
    always_comb begin
        state_d  = state_q;
        cmd_wr_d = cmd_wr_q;
        addr_d   = addr_q;
        rsp_d    = rsp_q;
        regs_d   = regs_q;
        unique case (state_q)
            ST_IDLE: begin
                if (byte_acc) begin
                    if (out_data_i == CMD_RD || out_data_i == CMD_WR) begin
                        cmd_wr_d = (out_data_i == CMD_WR);
                        state_d  = ST_ADDR;
                    end else begin
                        rsp_d   = RSP_NAK;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_ADDR: begin
                if (byte_acc) begin
                    addr_d = out_data_i;
                    if (cmd_wr_q) begin
                        state_d = ST_DATA;
                    end else begin
                        rsp_d   = rd_val;
                        state_d = ST_RESP;
                    end
                end else if (tmo_hit) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (byte_acc) begin
                    if (wr_ok) begin
                        for (int k = 1; k < int'(NREGS); k++) begin
                            if (wr_sel[k]) begin
                                regs_d[k] = out_data_i;
                            end
                        end
                        rsp_d = RSP_ACK;
                    end else begin
                        rsp_d = RSP_NAK;
                    end
                    state_d = ST_RESP;
                end else if (tmo_hit) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RESP: begin
                if (in_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; out_ready is registered so it is low during reset and drops
    // on the same edge that accepts a command's final byte.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= ST_IDLE;
            cmd_wr_q    <= 1'b0;
            addr_q      <= 8'h00;
            rsp_q       <= 8'h00;
            regs_q      <= '0;
            out_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_wr_q    <= cmd_wr_d;
            addr_q      <= addr_d;
            rsp_q       <= rsp_d;
            regs_q      <= regs_d;
            out_ready_q <= (state_d != ST_RESP);
        end
    end

    assign out_ready_o = out_ready_q;
    assign in_valid_o  = (state_q == ST_RESP);
    assign in_data_o   = rsp_q;
    // Register 0 is the read-only ID, not a control; its slot on regs_o reads as zero.
    assign regs_o      = {regs_q, 8'h00};
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_cdc_reg_responder.sv
// Self-checking bench for cdc_reg_responder: directed table, multi-cycle corner
// sequences and randomized commands against a byte-level register model.
// Build with +define+CDC_RSP_TIMEOUT_EN to cover the inter-byte timeout.
module tb_cdc_reg_responder;
    import cdc_rsp_pkg::*;

    localparam int unsigned NREGS = 16;
    localparam logic [7:0]  IDV   = 8'hC5;
    localparam int unsigned TMO   = 100;
    localparam int          CW    = 128;

    logic               clk_i = 1'b0;
    logic               rstn_i;
    logic [7:0]         out_data_i;
    logic               out_valid_i;
    logic               out_ready_o;
    logic [7:0]         in_data_o;
    logic               in_valid_o;
    logic               in_ready_i;
    logic [NREGS*8-1:0] regs_o;
    logic [1:0]         dbg_state_o;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mem[256];

    cdc_reg_responder #(
        .NREGS(NREGS), .ID_VALUE(IDV), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .out_data_i(out_data_i), .out_valid_i(out_valid_i), .out_ready_o(out_ready_o),
        .in_data_o(in_data_o), .in_valid_o(in_valid_o), .in_ready_i(in_ready_i),
        .regs_o(regs_o), .dbg_state_o(dbg_state_o)
    );

    // clock / watchdog
    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // reference model: command semantics at byte level
    function automatic int cmd_len(input logic [7:0] b0);
        if (b0 == 8'h52) return 2;
        if (b0 == 8'h57) return 3;
        return 1;
    endfunction

    function automatic logic [7:0] model_cmd(input logic [7:0] b0, b1, b2);
        if (b0 == 8'h52) begin
            if (b1 == 0) return IDV;
            if (int'(b1) < int'(NREGS)) return mem[b1];
            return 8'h15;
        end
        if (b0 == 8'h57) begin
            if (b1 != 0 && int'(b1) < int'(NREGS)) begin
                mem[b1] = b2;
                return 8'h06;
            end
            return 8'h15;
        end
        return 8'h15;
    endfunction

    function automatic logic [NREGS*8-1:0] model_regs();
        logic [NREGS*8-1:0] r = '0;
        for (int k = 1; k < int'(NREGS); k++) r[k*8 +: 8] = mem[k];
        return r;
    endfunction

    // driver tasks (all start and end at a negedge)
    task automatic send_byte(input logic [7:0] b);
        int guard = 0;
        out_data_i  = b;
        out_valid_i = 1'b1;
        while (!out_ready_o && guard < 200) begin
            @(negedge clk_i);
            guard++;
        end
        if (!out_ready_o) check("send_ready_timeout", CW'(0), CW'(1));
        @(posedge clk_i);
        #1;
        out_valid_i = 1'b0;
        out_data_i  = 8'h00;
        @(negedge clk_i);
    endtask

    task automatic recv_check(input string name, input int hold);
        logic [7:0] e;
        e = exp_q.pop_front();
        check({name, "_valid_latency"}, CW'(in_valid_o), CW'(1));
        check({name, "_data"}, CW'(in_data_o), CW'(e));
        check({name, "_out_ready_low"}, CW'(out_ready_o), CW'(0));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk_i);
            check({name, "_hold_data"}, CW'({in_valid_o, in_data_o}), CW'({1'b1, e}));
        end
        in_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        in_ready_i = 1'b0;
        @(negedge clk_i);
        check({name, "_valid_drop"}, CW'(in_valid_o), CW'(0));
        check({name, "_out_ready_rise"}, CW'(out_ready_o), CW'(1));
    endtask

    task automatic do_cmd(input string name, input logic [7:0] b0, b1, b2,
                          input logic [7:0] exp, input int gap, input int hold);
        int n;
        n = cmd_len(b0);
        exp_q.push_back(exp);
        send_byte(b0);
        if (n > 1) begin
            repeat (gap) @(negedge clk_i);
            send_byte(b1);
        end
        if (n > 2) begin
            repeat (gap) @(negedge clk_i);
            send_byte(b2);
        end
        recv_check(name, hold);
    endtask

    typedef struct {
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[13];

    initial begin
        logic [7:0] a, d, c, r;
        vecs[0]  = '{8'h52, 8'h00, 8'h00, 8'hC5};
        vecs[1]  = '{8'h57, 8'h03, 8'hA5, 8'h06};
        vecs[2]  = '{8'h52, 8'h03, 8'h00, 8'hA5};
        vecs[3]  = '{8'h57, 8'h00, 8'h11, 8'h15};
        vecs[4]  = '{8'h52, 8'h00, 8'h00, 8'hC5};
        vecs[5]  = '{8'h52, 8'h10, 8'h00, 8'h15};
        vecs[6]  = '{8'h41, 8'h00, 8'h00, 8'h15};
        vecs[7]  = '{8'h52, 8'hFF, 8'h00, 8'h15};
        vecs[8]  = '{8'h57, 8'h0F, 8'h3C, 8'h06};
        vecs[9]  = '{8'h52, 8'h0F, 8'h00, 8'h3C};
        vecs[10] = '{8'h57, 8'h10, 8'h77, 8'h15};
        vecs[11] = '{8'h57, 8'hFF, 8'h01, 8'h15};
        vecs[12] = '{8'h52, 8'h0F, 8'h00, 8'h3C};

        foreach (mem[i]) mem[i] = 8'h00;

        // reset
        rstn_i      = 1'b0;
        out_data_i  = 8'h00;
        out_valid_i = 1'b0;
        in_ready_i  = 1'b0;
        repeat (3) @(negedge clk_i);
        check("rst_out_ready", CW'(out_ready_o), CW'(0));
        check("rst_in_valid", CW'(in_valid_o), CW'(0));
        check("rst_in_data", CW'(in_data_o), CW'(0));
        check("rst_regs", CW'(regs_o), CW'(0));
        check("rst_state", CW'(dbg_state_o), CW'(ST_IDLE));
        rstn_i = 1'b1;
        @(negedge clk_i);
        check("post_rst_out_ready", CW'(out_ready_o), CW'(1));

        // directed table
        for (int i = 0; i < 13; i++) begin
            void'(model_cmd(vecs[i].b0, vecs[i].b1, vecs[i].b2));
            do_cmd($sformatf("vec%0d", i), vecs[i].b0, vecs[i].b1, vecs[i].b2,
                   vecs[i].exp, i % 3, i % 2);
        end
        check("regs_reg3", CW'(regs_o[31:24]), CW'(8'hA5));
        check("regs_table", CW'(regs_o), CW'(model_regs()));

        // unknown command with the host stalling the reply for 20 cycles
        exp_q.push_back(8'h15);
        send_byte(8'h41);
        out_data_i  = 8'h52;
        out_valid_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            check("stall_data", CW'({in_valid_o, in_data_o}), CW'({1'b1, 8'h15}));
            check("stall_out_ready", CW'(out_ready_o), CW'(0));
        end
        out_valid_i = 1'b0;
        out_data_i  = 8'h00;
        recv_check("stall", 0);
        check("stall_state_idle", CW'(dbg_state_o), CW'(ST_IDLE));

        // reset in the middle of a write command
        send_byte(8'h57);
        send_byte(8'h05);
        rstn_i = 1'b0;
        @(negedge clk_i);
        check("midrst_in_valid", CW'(in_valid_o), CW'(0));
        check("midrst_regs", CW'(regs_o), CW'(0));
        check("midrst_state", CW'(dbg_state_o), CW'(ST_IDLE));
        rstn_i = 1'b1;
        foreach (mem[i]) mem[i] = 8'h00;
        repeat (2) @(negedge clk_i);
        check("midrst_no_spurious", CW'(in_valid_o), CW'(0));
        do_cmd("midrst_rd", 8'h52, 8'h05, 8'h00, 8'h00, 0, 0);

`ifdef CDC_RSP_TIMEOUT_EN
        // abandoned write aborts after TMO idle cycles without a reply
        send_byte(8'h57);
        send_byte(8'h05);
        repeat (TMO - 1) @(negedge clk_i);
        check("tmo_still_data", CW'(dbg_state_o), CW'(ST_DATA));
        @(negedge clk_i);
        check("tmo_idle", CW'(dbg_state_o), CW'(ST_IDLE));
        check("tmo_no_reply", CW'(in_valid_o), CW'(0));
        do_cmd("tmo_rd", 8'h52, 8'h05, 8'h00, model_cmd(8'h52, 8'h05, 8'h00), 0, 0);
`else
        // a partial command keeps waiting for its remaining bytes
        send_byte(8'h57);
        send_byte(8'h05);
        repeat (150) @(negedge clk_i);
        check("wait_state_data", CW'(dbg_state_o), CW'(ST_DATA));
        check("wait_no_reply", CW'(in_valid_o), CW'(0));
        exp_q.push_back(model_cmd(8'h57, 8'h05, 8'h09));
        send_byte(8'h09);
        recv_check("wait_wr", 0);
        do_cmd("wait_rd", 8'h52, 8'h05, 8'h00, model_cmd(8'h52, 8'h05, 8'h00), 0, 0);
`endif

        // randomized commands against the model
        for (int i = 0; i < 60; i++) begin
            a = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(16, 255))
                                            : 8'($urandom_range(0, 17));
            d = 8'($urandom);
            case ($urandom_range(0, 4))
                0, 1: c = 8'h52;
                2, 3: c = 8'h57;
                default: begin
                    c = 8'($urandom);
                    if (c == 8'h52 || c == 8'h57) c = 8'h00;
                end
            endcase
            r = model_cmd(c, a, d);
            do_cmd($sformatf("rnd%0d", i), c, a, d, r,
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end
        check("regs_final", CW'(regs_o), CW'(model_regs()));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
